// File: rtl/des_key_scheduler.sv
// DES round-key sequencer: rotates the PC-1 key halves each round and issues PC-2 round keys over valid/ready.
// Optional reverse (decrypt) schedule is built when DES_KEY_DECRYPT_EN is defined.

module p_key2 (
  input  logic [55:0] cd,
  output logic [47:0] k
);
  // Output bit 1 (MSB) takes input bit PC2[0], input bits numbered 1..56 from the MSB.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign k[47-i] = cd[56-PC2[i]];
  end

  // Bits 9, 18, 22, 25, 35, 38, 43, 54 are discarded by PC-2.
  logic unused_bits;
  assign unused_bits = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};
endmodule

module des_key_scheduler #(
  parameter int KEY_W  = 56,
  parameter int RK_W   = 48,
  parameter int ROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_dec,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  rk_out,
  output logic [4:0]       rk_round,
  output logic             done
);
  localparam int HALF = KEY_W / 2;
  localparam logic [4:0] LAST = 5'(ROUNDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]      state;
  logic [HALF-1:0] c_q, d_q;
  logic [HALF-1:0] c_rot, d_rot;
  logic [4:0]      r;
  logic [1:0]      amt;
  logic [RK_W-1:0] pc2_out;
  logic            advance;

  function automatic logic [HALF-1:0] rotl(input logic [HALF-1:0] x, input logic [1:0] n);
    case (n)
      2'd0:    rotl = x;
      2'd1:    rotl = {x[HALF-2:0], x[HALF-1]};
      default: rotl = {x[HALF-3:0], x[HALF-1:HALF-2]};
    endcase
  endfunction

`ifdef DES_KEY_DECRYPT_EN
  logic mode_q;

  function automatic logic [HALF-1:0] rotr(input logic [HALF-1:0] x, input logic [1:0] n);
    case (n)
      2'd0:    rotr = x;
      2'd1:    rotr = {x[0], x[HALF-1:1]};
      default: rotr = {x[1:0], x[HALF-1:2]};
    endcase
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode_dec;
`endif

  always_comb begin
    amt = 2'd2;
    if (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == LAST) amt = 2'd1;
`ifdef DES_KEY_DECRYPT_EN
    // Reverse schedule starts from the fully rotated key, so round 1 leaves C/D untouched.
    if (mode_q && r == 5'd1) amt = 2'd0;
    c_rot = mode_q ? rotr(c_q, amt) : rotl(c_q, amt);
    d_rot = mode_q ? rotr(d_q, amt) : rotl(d_q, amt);
`else
    c_rot = rotl(c_q, amt);
    d_rot = rotl(d_q, amt);
`endif
  end

  p_key2 u_pc2 (
    .cd ({c_rot, d_rot}),
    .k  (pc2_out)
  );

  assign advance = !rk_valid || rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      c_q      <= '0;
      d_q      <= '0;
      r        <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_round <= '0;
      done     <= 1'b0;
`ifdef DES_KEY_DECRYPT_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done cycle is already IDLE; a start there is deliberately dropped.
          if (start && !done) begin
            c_q   <= key_in[KEY_W-1:HALF];
            d_q   <= key_in[HALF-1:0];
            r     <= 5'd1;
            busy  <= 1'b1;
            state <= S_LOAD;
`ifdef DES_KEY_DECRYPT_EN
            mode_q <= mode_dec;
`endif
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          if (advance) begin
            if (r <= LAST) begin
              c_q      <= c_rot;
              d_q      <= d_rot;
              rk_out   <= pc2_out;
              rk_round <= r;
              rk_valid <= 1'b1;
              r        <= r + 5'd1;
            end else begin
              rk_valid <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: a cumulative-rotation DES key model checked every cycle, pinned by known vectors.

module tb_des_key_scheduler;
  localparam logic [55:0] KEY_T = 56'hF0CCAAF556678F;
  localparam logic [47:0] K1    = 48'h1B02EFFC7072;
  localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

  localparam int PC2T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode_dec;
  logic [55:0] key_in;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] rk_out;
  logic [4:0]  rk_round;
  logic        done;

  des_key_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode_dec (mode_dec),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Written only by the stimulus process.
  logic [55:0] cur_key;
  bit          cur_dec;
  bit          tracking;
  int          epoch;
  int          exp_done_cyc;
  int          chk_idle;

  // Written only by the compare process.
  int          n_checks;
  int          n_fails;
  int          exp_idx;
  int          cyc;
  int          seen_epoch;
  bit          active;
  bit          seen_first;
  bit          prev_stall;
  logic [47:0] prev_out;
  logic [4:0]  prev_round;

  // Key n of the encrypt schedule is PC-2 of the key halves rotated left by the running shift total.
  function automatic logic [47:0] model_key(input logic [55:0] key, input int rnd, input bit dec);
    int shifts [16];
    int n;
    int tot;
    logic [55:0] cc;
    logic [55:0] dd;
    logic [55:0] cd;
    logic [47:0] k;
    shifts = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    n = dec ? 17 - rnd : rnd;
    tot = 0;
    for (int i = 0; i < n; i++) tot += shifts[i];
    tot = tot % 28;
    cc = {key[55:28], key[55:28]} << tot;
    dd = {key[27:0], key[27:0]} << tot;
    cd = {cc[55:28], dd[55:28]};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2T[i]];
    return k;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_idle != 0) begin
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_rk_valid", 64'(rk_valid), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      if (chk_idle == 2) begin
        check("reset_rk_out", 64'(rk_out), 64'd0);
        check("reset_rk_round", 64'(rk_round), 64'd0);
      end
    end
    if (tracking && epoch != seen_epoch) begin
      seen_epoch = epoch;
      active     = 1'b1;
      exp_idx    = 1;
      cyc        = -1;
      seen_first = 1'b0;
      prev_stall = 1'b0;
    end else begin
      cyc++;
    end
    if (tracking && active) begin
      if (cyc >= 0) check("busy", 64'(busy), done ? 64'd0 : 64'd1);
      if (rk_valid) begin
        if (!seen_first) begin
          seen_first = 1'b1;
          check("first_key_latency", 64'(cyc), 64'd2);
        end
        check("rk_round", 64'(rk_round), 64'(exp_idx));
        check("rk_out", 64'(rk_out), 64'(model_key(cur_key, exp_idx, cur_dec)));
        if (prev_stall) begin
          check("hold_rk_out", 64'(rk_out), 64'(prev_out));
          check("hold_rk_round", 64'(rk_round), 64'(prev_round));
        end
        if (cur_key == KEY_T && exp_idx == 1)
          check("pin_round1", 64'(rk_out), 64'(cur_dec ? K16 : K1));
        if (cur_key == KEY_T && exp_idx == 16)
          check("pin_round16", 64'(rk_out), 64'(cur_dec ? K1 : K16));
        if (cur_key == 56'h0)
          check("pin_zero_key", 64'(rk_out), 64'd0);
        if (cur_key == 56'hFFFFFFFFFFFFFF)
          check("pin_ones_key", 64'(rk_out), 64'hFFFFFFFFFFFF);
        if (rk_ready) exp_idx++;
      end
      if (done) begin
        check("keys_issued", 64'(exp_idx - 1), 64'd16);
        check("done_cycle", 64'(cyc), 64'(exp_done_cyc));
        active = 1'b0;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_out   = rk_out;
      prev_round = rk_round;
    end
  end

  // Starts one schedule and drives it until done; optional stall, stray start, or reset at given rounds.
  task automatic run_sched(input logic [55:0] key, input bit dec, input int stall_round,
                           input int stall_len, input int poke_round, input int rst_round);
    int stalls;
    bit poked;
    stalls = 0;
    poked  = 1'b0;
    @(posedge clk); #1;
    key_in       = key;
    mode_dec     = dec;
    start        = 1'b1;
    rk_ready     = 1'b1;
    cur_key      = key;
`ifdef DES_KEY_DECRYPT_EN
    cur_dec      = dec;
`else
    cur_dec      = 1'b0;
`endif
    exp_done_cyc = 18 + stall_len;
    epoch++;
    tracking     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      rk_ready = 1'b1;
      start    = 1'b0;
      if (rk_valid && rk_round == 5'(stall_round) && stalls < stall_len) begin
        rk_ready = 1'b0;
        stalls++;
      end
      if (rk_valid && rk_round == 5'(poke_round) && !poked) begin
        start    = 1'b1;
        key_in   = ~key;
        mode_dec = ~dec;
        poked    = 1'b1;
      end
      if (rk_valid && rk_round == 5'(rst_round)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        start    = 1'b0;
        tracking = 1'b0;
        chk_idle = 2;
        @(posedge clk); #1;
        chk_idle = 0;
        return;
      end
      @(negedge clk);
      if (done) return;
      @(posedge clk); #1;
    end
    $display("FAIL schedule_timeout: got no done within 100 cycles, required done");
    $fatal(1, "schedule did not complete");
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    seen_epoch = 0;
    active     = 1'b0;
    cyc        = 0;
    exp_idx    = 0;
    rst        = 1'b1;
    start      = 1'b0;
    mode_dec   = 1'b0;
    key_in     = '0;
    rk_ready   = 1'b1;
    tracking   = 1'b0;
    epoch      = 0;
    chk_idle   = 0;
    cur_key    = '0;
    cur_dec    = 1'b0;
    exp_done_cyc = 0;

    repeat (2) @(posedge clk);
    #1 chk_idle = 2;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle = 0;

    // Encrypt, full-rate consumer.
    run_sched(KEY_T, 1'b0, 0, 0, 0, 0);
    // Back-pressure on round 3, then start on the cycle after done.
    run_sched(KEY_T, 1'b0, 3, 5, 0, 0);
    // Stray start during round 7 must not disturb the schedule.
    run_sched(KEY_T, 1'b0, 0, 0, 7, 0);
    // Degenerate keys: every round key all-zero / all-one.
    run_sched(56'h0, 1'b0, 0, 0, 0, 0);
    run_sched(56'hFFFFFFFFFFFFFF, 1'b0, 0, 0, 0, 0);

    // start raised during the done cycle is dropped.
    #1;
    tracking = 1'b0;
    start    = 1'b1;
    key_in   = 56'h1;
    @(posedge clk); #1;
    start    = 1'b0;
    chk_idle = 1;
    @(posedge clk); #1;
    chk_idle = 0;

    // Reset during round 10, then a normal schedule.
    run_sched(KEY_T, 1'b0, 0, 0, 0, 10);
    run_sched(56'h123456789ABCDE, 1'b0, 6, 2, 0, 0);

    // mode_dec = 1: reverse schedule when built with decrypt support, encrypt otherwise.
    run_sched(KEY_T, 1'b1, 0, 0, 0, 0);
    run_sched(KEY_T, 1'b1, 9, 3, 0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
